// File: rtl/inst_prefetcher_pkg.sv
// inst_prefetcher_pkg
//   Shared constants and types for the instruction prefetcher:
//   PC/word widths, request FSM state encoding, pointer-width helper.
package inst_prefetcher_pkg;

  localparam int REG_BITS = 8;
  localparam int PC_W     = 2 * REG_BITS;  // architectural PC and word address width
  localparam int WORD_W   = 16;            // instruction word width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request in progress
    ST_REQ  = 2'd1,  // request presented, waiting for fetch_req_ready
    ST_WAIT = 2'd2   // request accepted, waiting for the response strobe
  } req_state_t;

  // Index width for a circular structure of the given depth (min 1 bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_prefetcher_if.sv
// inst_prefetcher_if
//   Memory-side fetch bus of the instruction prefetcher.
//   master (prefetcher): fetch_req_valid, fetch_addr out; fetch_req_ready,
//                        fetch_data_valid, fetch_data in.
//   slave  (memory)    : the mirror image.
//
// Handshake: a request transfers in the cycle where fetch_req_valid and
// fetch_req_ready are both high; fetch_addr is held stable while
// fetch_req_valid is high and not yet accepted (the only exception is a PC
// commit in the discard-enabled build, which may withdraw an unaccepted
// request). At most one request is outstanding; its response is a
// single-cycle fetch_data_valid strobe with fetch_data, with no back-pressure.
interface inst_prefetcher_if;
  import inst_prefetcher_pkg::*;

  logic              fetch_req_valid;
  logic [PC_W-1:0]   fetch_addr;
  logic              fetch_req_ready;
  logic              fetch_data_valid;
  logic [WORD_W-1:0] fetch_data;

  modport master (
    output fetch_req_valid, fetch_addr,
    input  fetch_req_ready, fetch_data_valid, fetch_data
  );

  modport slave (
    input  fetch_req_valid, fetch_addr,
    output fetch_req_ready, fetch_data_valid, fetch_data
  );

endinterface

// File: rtl/inst_prefetcher_fifo.sv
// prefetch_fifo
//   DEPTH x W circular instruction queue.
//   clk, reset : clock, synchronous active-high reset
//   push/wr_data : append a word (caller guarantees not full)
//   pop          : drop the head (caller guarantees not empty)
//   keep_head    : drop every entry except the head; combined with pop the
//                  queue ends empty. push is ignored in a keep_head cycle.
//   head         : head word, 0 when empty
//   count        : number of valid entries
module prefetch_fifo
  import inst_prefetcher_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     wr_data,
  input  logic             pop,
  input  logic             keep_head,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (keep_head) begin
      // Flush: rewind the write pointer to just behind the head.
      if (pop) begin
        rd_ptr <= inc(rd_ptr);
        wr_ptr <= inc(rd_ptr);
        count  <= '0;
      end else if (count != '0) begin
        wr_ptr <= inc(rd_ptr);
        count  <= CNT_W'(1);
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_prefetcher.sv
// inst_prefetcher
//   Instruction prefetch stage feeding the decoder. Fetches 16-bit words
//   into a QUEUE_DEPTH queue, presents the head, owns the architectural PC
//   (serial read/write NSHIFT bits at a time) and redirects fetch on commit.
//   Optional build macro: PREFETCH_DISCARD_EN allows a commit while a request
//   is in REQ or WAIT (request withdrawn / stale response discarded).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   inst_valid, inst   queue head and its valid
//   inst_done          decoder pops the head
//   imm_data_in        immediate chunk of inst[7:0] at imm_ptr
//   next_imm_data      advance imm_ptr
//   block_prefetch     suppress new requests
//   write_pc           write pc chunk comp_counter with pc_data_out
//   ext_pc_next        commit pc, redirect fetch, flush all but head
//   comp_counter       pc chunk index for reads/writes
//   prefetch_idle      no request pending or outstanding
//   pc_data_out/in     serial pc write data / read data
//   fbus               memory fetch bus (master side)
//   fetch_state        request FSM state, for observation
module inst_prefetcher
  import inst_prefetcher_pkg::*;
#(
  parameter int              NSHIFT      = 2,
  parameter int              QUEUE_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               inst_valid,
  output logic [WORD_W-1:0]  inst,
  input  logic               inst_done,
  output logic [NSHIFT-1:0]  imm_data_in,
  input  logic               next_imm_data,
  input  logic               block_prefetch,
  input  logic               write_pc,
  input  logic               ext_pc_next,
  input  logic [2:0]         comp_counter,
  output logic               prefetch_idle,
  input  logic [NSHIFT-1:0]  pc_data_out,
  output logic [NSHIFT-1:0]  pc_data_in,
  inst_prefetcher_if.master  fbus,
  output req_state_t         fetch_state
);

  localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1);
  localparam int IMM_CHUNKS = 8 / NSHIFT;
  localparam int IMM_W      = ptr_w(IMM_CHUNKS);

  req_state_t       state, state_next;
  logic [PC_W-1:0]  pc, pc_next;
  logic [PC_W-1:0]  fetch_ptr;
  logic             outstanding;
  logic             stale_head;
  logic [IMM_W-1:0] imm_ptr;
  logic [CNT_W-1:0] count;
  logic             pop, push, rsp, accept, room;

  assign inst_valid = (count != '0);
  assign pop        = inst_done && inst_valid;
  assign rsp        = (state == ST_WAIT) && fbus.fetch_data_valid;
  assign accept     = (state == ST_REQ) && fbus.fetch_req_ready;
  assign room       = (int'(count) + int'(outstanding)) < QUEUE_DEPTH;

`ifdef PREFETCH_DISCARD_EN
  logic discard;
  // A response arriving in the commit cycle belongs to the old stream.
  assign push = rsp && !discard && !ext_pc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      discard <= 1'b0;
    end else if (ext_pc_next &&
                 ((state == ST_WAIT && !fbus.fetch_data_valid) || accept)) begin
      discard <= 1'b1;
    end else if (rsp) begin
      discard <= 1'b0;
    end
  end
`else
  assign push = rsp;

  commit_only_when_idle: assert property (
    @(posedge clk) disable iff (reset) ext_pc_next |-> prefetch_idle);
`endif

  prefetch_fifo #(.DEPTH(QUEUE_DEPTH), .W(WORD_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .wr_data   (fbus.fetch_data),
    .pop       (pop),
    .keep_head (ext_pc_next),
    .head      (inst),
    .count     (count)
  );

  // Request FSM
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      // No new request in a commit cycle: fetch_ptr is not yet redirected.
      ST_IDLE: if (!block_prefetch && !ext_pc_next && room) state_next = ST_REQ;
      ST_REQ: begin
        if (fbus.fetch_req_ready) state_next = ST_WAIT;
`ifdef PREFETCH_DISCARD_EN
        else if (ext_pc_next)     state_next = ST_IDLE;
`endif
      end
      ST_WAIT: if (fbus.fetch_data_valid) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign fbus.fetch_req_valid = (state == ST_REQ);
  assign fbus.fetch_addr      = fetch_ptr;
  assign prefetch_idle        = (state == ST_IDLE) && !outstanding;
  assign fetch_state          = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_ptr   <= RESET_PC;
      outstanding <= 1'b0;
    end else begin
      if (ext_pc_next) fetch_ptr <= pc;
      else if (accept) fetch_ptr <= fetch_ptr + 1'b1;
      if (accept)   outstanding <= 1'b1;
      else if (rsp) outstanding <= 1'b0;
    end
  end

  // PC: a pop advances it unless the head was already jumped past
  // (stale_head) or a commit in the same cycle supplies the new value.
  always_comb begin
    pc_next = pc;
    if (pop && !stale_head && !ext_pc_next) pc_next = pc + 1'b1;
    if (write_pc) pc_next[comp_counter*NSHIFT +: NSHIFT] = pc_data_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      stale_head <= 1'b0;
      imm_ptr    <= '0;
    end else begin
      pc <= pc_next;
      if (ext_pc_next) stale_head <= inst_valid && !pop;
      else if (pop)    stale_head <= 1'b0;
      if (pop)
        imm_ptr <= '0;
      else if (next_imm_data)
        imm_ptr <= (imm_ptr == IMM_W'(IMM_CHUNKS - 1)) ? '0 : imm_ptr + 1'b1;
    end
  end

  assign imm_data_in = inst[imm_ptr*NSHIFT +: NSHIFT];
  assign pc_data_in  = pc[comp_counter*NSHIFT +: NSHIFT];

endmodule
